// File: rtl/color_scan_sequencer.sv
// Colour sensor scan sequencer for a TCS3200-style sensor.
// Steps the filter select through clear, red, blue and green. For each filter it
// waits a settle time, then counts synchronised sensor edges over a gate window.
// All four counts are published together, alongside a one-cycle done pulse.
// Optional build macro COLOR_SCAN_AUTO_REPEAT_EN: a start held high through DONE
// chains straight into the next scan.
module color_scan_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 10000,
   parameter int unsigned GATE_CYCLES   = 100000,
   parameter int unsigned CNT_W         = 18
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             sensor_out,
   output logic             S0,
   output logic             S1,
   output logic             S2,
   output logic             S3,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] clear_count,
   output logic [CNT_W-1:0] red_count,
   output logic [CNT_W-1:0] blue_count,
   output logic [CNT_W-1:0] green_count,
   output logic             overflow
);

   localparam int unsigned TMAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [2:0] {IDLE, SETTLE, GATE, NEXT, DONE} state_t;
   typedef enum logic [1:0] {CH_CLEAR, CH_RED, CH_BLUE, CH_GREEN} ch_t;

   state_t           state, state_nx;
   ch_t              ch, filt;
   logic [TW-1:0]    timer;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic [CNT_W-1:0] shadow [4];
   logic [3:0]       sat;
   logic             start_d, start_edge;
   logic             sens_meta, sens_sync, sens_prev, sens_edge;

   function automatic logic [1:0] filter_code(ch_t c);
      case (c)
         CH_CLEAR: filter_code = 2'b10;
         CH_RED:   filter_code = 2'b00;
         CH_BLUE:  filter_code = 2'b01;
         default:  filter_code = 2'b11;
      endcase
   endfunction

   assign S0         = 1'b1;
   assign S1         = 1'b1;
   assign start_edge = start & ~start_d;
   assign sens_edge  = sens_sync & ~sens_prev;
   assign cnt_inc    = (sens_edge && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state decode and filter-select / busy outputs
   always_comb begin
      state_nx = state;
      filt     = CH_CLEAR;
      case (state)
         IDLE:   if (start_edge) state_nx = SETTLE;
         SETTLE: begin
            filt = ch;
            if (timer == SETTLE_LAST) state_nx = GATE;
         end
         GATE: begin
            filt = ch;
            if (timer == GATE_LAST) state_nx = NEXT;
         end
         NEXT: begin
            // The new filter is presented during NEXT so settling starts one cycle early.
            if (ch == CH_GREEN) begin
               filt     = CH_GREEN;
               state_nx = DONE;
            end else begin
               filt     = ch_t'(ch + 2'd1);
               state_nx = SETTLE;
            end
         end
         DONE: begin
`ifdef COLOR_SCAN_AUTO_REPEAT_EN
            state_nx = start ? SETTLE : IDLE;
`else
            state_nx = IDLE;
`endif
         end
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
      {S2, S3} = filter_code(filt);
      busy     = (state != IDLE);
   end

   // Input conditioning, timer, channel counter, shadow and published results
   always_ff @(posedge clock) begin
      if (reset) begin
         start_d     <= 1'b0;
         sens_meta   <= 1'b0;
         sens_sync   <= 1'b0;
         sens_prev   <= 1'b0;
         timer       <= '0;
         cnt         <= '0;
         ch          <= CH_CLEAR;
         sat         <= '0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         clear_count <= '0;
         red_count   <= '0;
         blue_count  <= '0;
         green_count <= '0;
         for (int unsigned i = 0; i < 4; i++) shadow[i] <= '0;
      end else begin
         start_d   <= start;
         sens_meta <= sensor_out;
         sens_sync <= sens_meta;
         sens_prev <= sens_sync;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               timer <= '0;
               cnt   <= '0;
               ch    <= CH_CLEAR;
            end
            SETTLE: timer <= (timer == SETTLE_LAST) ? '0 : timer + 1'b1;
            GATE: begin
               cnt <= cnt_inc;
               if (timer == GATE_LAST) begin
                  timer      <= '0;
                  shadow[ch] <= cnt_inc;
                  sat[ch]    <= (cnt_inc == CNT_MAX);
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            NEXT: begin
               timer <= '0;
               cnt   <= '0;
               if (ch != CH_GREEN) ch <= ch_t'(ch + 2'd1);
            end
            DONE: begin
               timer <= '0;
               cnt   <= '0;
               ch    <= CH_CLEAR;
               if (!abort) begin
                  clear_count <= shadow[0];
                  red_count   <= shadow[1];
                  blue_count  <= shadow[2];
                  green_count <= shadow[3];
                  overflow    <= |sat;
                  done        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Self-checking bench for color_scan_sequencer: table of scans plus hand-written
// abort / reset / busy-start / held-start sequences, against a timing-level model.
module tb_color_scan_sequencer;
   localparam int S  = 4;
   localparam int G  = 16;
   localparam int GS = 1024;
   localparam int W  = 8;
   localparam int CMAX = (1 << W) - 1;

   logic clock = 1'b0;
   logic reset, start, start2, abort, sensor_out;
   logic s0a, s1a, s2a, s3a, busy_a, done_a, ovf_a;
   logic s0b, s1b, s2b, s3b, busy_b, done_b, ovf_b;
   logic [W-1:0] cc_a, rc_a, bc_a, gc_a, cc_b, rc_b, bc_b, gc_b;

   color_scan_sequencer #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(W)) u_main (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .sensor_out(sensor_out),
      .S0(s0a), .S1(s1a), .S2(s2a), .S3(s3a), .busy(busy_a), .done(done_a),
      .clear_count(cc_a), .red_count(rc_a), .blue_count(bc_a), .green_count(gc_a),
      .overflow(ovf_a));

   color_scan_sequencer #(.SETTLE_CYCLES(S), .GATE_CYCLES(GS), .CNT_W(W)) u_sat (
      .clock(clock), .reset(reset), .start(start2), .abort(abort), .sensor_out(sensor_out),
      .S0(s0b), .S1(s1b), .S2(s2b), .S3(s3b), .busy(busy_b), .done(done_b),
      .clear_count(cc_b), .red_count(rc_b), .blue_count(bc_b), .green_count(gc_b),
      .overflow(ovf_b));

   always #5 clock = ~clock;

   int cyc = 0;
   bit samp [0:32767];
   initial forever begin
      @(posedge clock);
      samp[cyc] = sensor_out;
      cyc++;
   end

   int vectors = 0, miscompares = 0;
   int mode = 0, sel = 0, ph = 0, cur_row = -1;
   int per [4];

   typedef struct {
      int sel; int mode; int p [4]; int ex [4]; int ovf; int use_ex;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] fcode(int c);
      case (c)
         0: return 2'b10;
         1: return 2'b00;
         2: return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   function automatic int fidx(logic [1:0] f);
      case (f)
         2'b10: return 0;
         2'b00: return 1;
         2'b01: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] cur_filt(int sl);
      return sl ? {s2b, s3b} : {s2a, s3a};
   endfunction

   function automatic logic [W-1:0] get_cnt(int sl, int c);
      case (c)
         0: return sl ? cc_b : cc_a;
         1: return sl ? rc_b : rc_a;
         2: return sl ? bc_b : bc_a;
         default: return sl ? gc_b : gc_a;
      endcase
   endfunction

   // Scan offset om counts cycles from the first SETTLE cycle of that scan.
   function automatic logic [1:0] exp_filter(int om, int s, int g);
      int pr = s + g + 1;
      int c, r;
      if (om >= 4 * pr) return 2'b10;
      c = om / pr;
      r = om % pr;
      if (r == pr - 1 && c < 3) return fcode(c + 1);
      return fcode(c);
   endfunction

   // Gate cycle i of channel c ends at posedge base+1+c*(s+g+1)+s+i; the edge seen
   // there was sampled two and three posedges earlier through the synchroniser.
   function automatic int model_cnt(int base, int c, int s, int g);
      int n = 0;
      int p0 = base + 1 + c * (s + g + 1) + s;
      for (int i = 0; i < g; i++) begin
         int p = p0 + i;
         if (samp[p-2] && !samp[p-3] && n < CMAX) n++;
      end
      return n;
   endfunction

   task automatic step();
      @(negedge clock);
      if (mode == 0) sensor_out = 1'($urandom % 2);
      else begin
         int pp = per[fidx(cur_filt(sel))];
         sensor_out = ((ph / (pp / 2)) % 2) != 0;
      end
      ph++;
   endtask

   task automatic set_start(input int sl, input logic v);
      if (sl != 0) start2 = v;
      else         start  = v;
   endtask

   task automatic run_scan(input int sl, input int hold, input int extra, input int nsc);
      int g = sl ? GS : G;
      int L = 4 * (S + g + 1) + 1;
      int rel = hold ? 3 * L - 30 : 1;
      int last = hold ? 3 * L + 8 : nsc * L + 8;
      int n = cyc;
      sel = sl;
      set_start(sl, 1'b1);
      for (int o = 0; o <= last; o++) begin
         logic edone;
         step();
         edone = (o > 0) && (o % L == 0) && (o / L <= nsc);
         chk("busy", sl ? busy_b : busy_a, (o <= nsc * L - 1));
         chk("done", sl ? done_b : done_a, edone);
         chk("filter", cur_filt(sl), (o < nsc * L) ? exp_filter(o % L, S, g) : 2'b10);
         if (edone) begin
            int base = n + (o / L - 1) * L;
            int any = 0;
            for (int c = 0; c < 4; c++) begin
               int m = model_cnt(base, c, S, g);
               if (m == CMAX) any = 1;
               chk("count_model", get_cnt(sl, c), m);
               if (cur_row >= 0 && tbl[cur_row].use_ex != 0)
                  chk("count_table", get_cnt(sl, c), tbl[cur_row].ex[c]);
            end
            chk("ovf_model", sl ? ovf_b : ovf_a, any);
            if (cur_row >= 0 && tbl[cur_row].use_ex != 0)
               chk("ovf_table", sl ? ovf_b : ovf_a, tbl[cur_row].ovf);
         end
         if (o == rel) set_start(sl, 1'b0);
         if (extra != 0 && o == 30) set_start(sl, 1'b1);
         if (extra != 0 && o == 32) set_start(sl, 1'b0);
      end
      set_start(sl, 1'b0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; sensor_out = 1'b0;
      tbl[0] = '{sel:0, mode:1, p:'{4,4,4,4},     ex:'{4,4,4,4},         ovf:0, use_ex:1};
      tbl[1] = '{sel:0, mode:1, p:'{2,4,8,16},    ex:'{8,4,2,1},         ovf:0, use_ex:1};
      tbl[2] = '{sel:1, mode:1, p:'{2,2,2,2},     ex:'{255,255,255,255}, ovf:1, use_ex:1};
      tbl[3] = '{sel:1, mode:1, p:'{16,16,16,16}, ex:'{64,64,64,64},     ovf:0, use_ex:1};
      tbl[4] = '{sel:0, mode:0, p:'{2,2,2,2},     ex:'{0,0,0,0},         ovf:0, use_ex:0};
      tbl[5] = '{sel:0, mode:0, p:'{2,2,2,2},     ex:'{0,0,0,0},         ovf:0, use_ex:0};

      repeat (3) step();
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_filter", {s2a, s3a}, 2'b10);
      chk("rst_s0s1", {s0a, s1a}, 2'b11);
      for (int c = 0; c < 4; c++) chk("rst_count", get_cnt(0, c), 0);
      reset = 1'b0;
      repeat (3) step();

      for (int r = 0; r < 6; r++) begin
         cur_row = r;
         mode = tbl[r].mode;
         for (int c = 0; c < 4; c++) per[c] = tbl[r].p[c];
         run_scan(tbl[r].sel, 0, 0, 1);
         repeat (4) step();
      end
      cur_row = -1;

      // Known-value scan, then abort during the blue gate window
      mode = 1;
      for (int c = 0; c < 4; c++) per[c] = 4;
      run_scan(0, 0, 0, 1);
      for (int c = 0; c < 4; c++) chk("pre_abort_count", get_cnt(0, c), 4);
      start = 1'b1;
      for (int o = 0; o <= 50; o++) begin
         step();
         if (o == 1) start = 1'b0;
      end
      chk("abort_busy_before", busy_a, 1);
      chk("abort_filter_before", {s2a, s3a}, 2'b01);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", busy_a, 0);
      chk("abort_filter", {s2a, s3a}, 2'b10);
      for (int i = 0; i < 100; i++) begin
         chk("abort_nodone", done_a, 0);
         step();
      end
      for (int c = 0; c < 4; c++) chk("abort_hold_count", get_cnt(0, c), 4);
      chk("abort_hold_ovf", ovf_a, 0);

      // Extra start pulses mid-scan yield exactly one done
      mode = 0;
      run_scan(0, 0, 1, 1);
      repeat (4) step();

      // Reset during the red settle phase
      mode = 1;
      run_scan(0, 0, 0, 1);
      start = 1'b1;
      for (int o = 0; o <= 22; o++) begin
         step();
         if (o == 1) start = 1'b0;
      end
      chk("midrst_filter_before", {s2a, s3a}, 2'b00);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_busy", busy_a, 0);
      chk("midrst_done", done_a, 0);
      chk("midrst_filter", {s2a, s3a}, 2'b10);
      for (int c = 0; c < 4; c++) chk("midrst_count", get_cnt(0, c), 0);
      repeat (3) step();

      // Abort and start in the same idle cycle: no scan
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      chk("abort_start_busy", busy_a, 0);
      step();
      chk("abort_start_busy2", busy_a, 0);
      repeat (3) step();

      // Start held high across several scan lengths
`ifdef COLOR_SCAN_AUTO_REPEAT_EN
      run_scan(0, 1, 0, 3);
`else
      run_scan(0, 1, 0, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
